// File: rtl/rast_params.sv
// ============================================================================
// Module   : rast_params
// Purpose  : Shared rasterizer widths, coordinate/box types and state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rast_params;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic signed [SIGFIG-1:0] coord_t;

  typedef struct packed {
    coord_t y;
    coord_t x;
  } point_t;

  typedef struct packed {
    point_t ur;
    point_t ll;
  } box_t;

  localparam logic [3:0] SS_1X = 4'b1000;
  localparam logic [3:0] SS_2X = 4'b0100;
  localparam logic [3:0] SS_4X = 4'b0010;
  localparam logic [3:0] SS_8X = 4'b0001;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/subsample_step.sv
// ============================================================================
// Module   : subsample_step
// Purpose  : One-hot subsample code to fixed-point step size decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subsample_step
  import rast_params::*;
(
  input  logic [3:0] subsample_in,
  output coord_t     step_out
);
  localparam coord_t c_one = coord_t'(1 << RADIX);

  // Anything that is not a clean one-hot code falls back to full-pixel pitch.
  always_comb begin
    step_out = c_one;
    case (subsample_in)
      SS_1X:   step_out = c_one;
      SS_2X:   step_out = c_one >>> 1;
      SS_4X:   step_out = c_one >>> 2;
      SS_8X:   step_out = c_one >>> 3;
      default: step_out = c_one;
    endcase
  end
endmodule

`default_nettype wire

// File: rtl/bbox_sample_iter.sv
// ============================================================================
// Module   : bbox_sample_iter
// Purpose  : Walks a triangle's bounding box in raster order, one sample/cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbox_sample_iter
  import rast_params::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]   tri_in,
  input  logic [COLORS*SIGFIG-1:0]       color_in,
  input  logic                           valid_in,
  input  logic [2*2*SIGFIG-1:0]          box_in,
  input  logic [3:0]                     subsample_in,
  input  logic                           halt_ds_in,
  output logic                           halt_us_out,
  output logic [VERTS*AXIS*SIGFIG-1:0]   tri_out,
  output logic [COLORS*SIGFIG-1:0]       color_out,
  output logic [2*SIGFIG-1:0]            sample_out,
  output logic                           valid_out,
  output logic                           busy_out
);
  typedef logic signed [SIGFIG:0] ext_t;

  function automatic ext_t ext(input coord_t v);
    return {v[SIGFIG-1], v};
  endfunction

  state_t                          r_state;
  state_t                          w_next_state;
  box_t                            w_box_in;
  box_t                            r_box;
  coord_t                          w_step_in;
  coord_t                          r_step;
  coord_t                          r_x;
  coord_t                          r_y;
  logic                            r_valid;
  logic [VERTS*AXIS*SIGFIG-1:0]    r_tri;
  logic [COLORS*SIGFIG-1:0]        r_color;

  ext_t w_nx;
  ext_t w_ny;
  ext_t w_in_nx;
  ext_t w_in_ny;
  logic w_x_wrap;
  logic w_at_last;
  logic w_accept;
  logic w_in_single;

  assign w_box_in = box_t'(box_in);

  subsample_step u_subsample_step (
    .subsample_in (subsample_in),
    .step_out     (w_step_in)
  );

  // One extra bit of headroom so x+step near the top of the range cannot wrap.
  assign w_nx      = ext(r_x) + ext(r_step);
  assign w_ny      = ext(r_y) + ext(r_step);
  assign w_x_wrap  = w_nx > ext(r_box.ur.x);
  assign w_at_last = w_x_wrap && (w_ny > ext(r_box.ur.y));

  assign w_in_nx     = ext(w_box_in.ll.x) + ext(w_step_in);
  assign w_in_ny     = ext(w_box_in.ll.y) + ext(w_step_in);
  assign w_in_single = (ext(w_box_in.ur.x) < ext(w_box_in.ll.x)) ||
                       (ext(w_box_in.ur.y) < ext(w_box_in.ll.y)) ||
                       ((w_in_nx > ext(w_box_in.ur.x)) && (w_in_ny > ext(w_box_in.ur.y)));

  // The last sample of a box doubles as the load slot for the next triangle.
  assign w_accept = !halt_ds_in && ((r_state == IDLE) || w_at_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_accept)
      w_next_state = (valid_in && !w_in_single) ? ITER : IDLE;
  end

  always_comb begin
    halt_us_out = halt_ds_in || ((r_state == ITER) && !w_at_last);
    busy_out    = (r_state == ITER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tri   <= '0;
      r_color <= '0;
      r_box   <= '0;
      r_step  <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (!halt_ds_in) begin
      if (w_accept) begin
        r_valid <= valid_in;
        if (valid_in) begin
          r_tri   <= tri_in;
          r_color <= color_in;
          r_box   <= w_box_in;
          r_step  <= w_step_in;
          r_x     <= w_box_in.ll.x;
          r_y     <= w_box_in.ll.y;
        end
      end else if (w_x_wrap) begin
        r_x <= r_box.ll.x;
        r_y <= r_y + r_step;
      end else begin
        r_x <= r_x + r_step;
      end
    end
  end

  assign sample_out = {r_y, r_x};
  assign valid_out  = r_valid;
  assign tri_out    = r_tri;
  assign color_out  = r_color;
endmodule

`default_nettype wire

// File: tb/tb_bbox_sample_iter.sv
// ============================================================================
// Module   : tb_bbox_sample_iter
// Purpose  : Directed self-checking bench for bbox_sample_iter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bbox_sample_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic [215:0] tri_in;
  logic [71:0]  color_in;
  logic         valid_in;
  logic [95:0]  box_in;
  logic [3:0]   subsample_in;
  logic         halt_ds_in;
  logic         halt_us_out;
  logic [215:0] tri_out;
  logic [71:0]  color_out;
  logic [47:0]  sample_out;
  logic         valid_out;
  logic         busy_out;

  int total = 0;
  int bad   = 0;

  bbox_sample_iter dut (
    .clk          (clk),
    .rst          (rst),
    .tri_in       (tri_in),
    .color_in     (color_in),
    .valid_in     (valid_in),
    .box_in       (box_in),
    .subsample_in (subsample_in),
    .halt_ds_in   (halt_ds_in),
    .halt_us_out  (halt_us_out),
    .tri_out      (tri_out),
    .color_out    (color_out),
    .sample_out   (sample_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mk_pt(input int x, input int y);
    return {y[23:0], x[23:0]};
  endfunction

  function automatic logic [95:0] mk_box(input int llx, input int lly, input int urx, input int ury);
    return {ury[23:0], urx[23:0], lly[23:0], llx[23:0]};
  endfunction

  task automatic present(input logic [95:0] box, input logic [3:0] ss, input logic [23:0] tag);
    valid_in     = 1'b1;
    box_in       = box;
    subsample_in = ss;
    tri_in       = {9{tag}};
    color_in     = {3{~tag}};
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; halt_ds_in = 1'b0; box_in = '0;
    subsample_in = 4'b1000; tri_in = '0; color_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (valid_out !== 1'b0 || sample_out !== 48'h0 || busy_out !== 1'b0 || halt_us_out !== 1'b0)
      begin bad++; $display("FAIL reset_state: got valid=%b sample=%h busy=%b halt_us=%b, want all 0",
                            valid_out, sample_out, busy_out, halt_us_out); end
    total++;
    if (tri_out !== 216'h0 || color_out !== 72'h0)
      begin bad++; $display("FAIL reset_data: got tri=%h color=%h, want 0", tri_out, color_out); end
    rst = 1'b0;
  endtask

  task automatic test_six_sample();
    logic [47:0] exp [6];
    logic        want_h;
    exp = '{mk_pt(0,0), mk_pt(1024,0), mk_pt(2048,0), mk_pt(0,1024), mk_pt(1024,1024), mk_pt(2048,1024)};
    present(mk_box(0, 0, 2048, 1024), 4'b1000, 24'hA1B2C3);
    #1;
    total++;
    if (halt_us_out !== 1'b0) begin bad++; $display("FAIL six_idle_halt: got %b want 0", halt_us_out); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin valid_in = 1'b0; subsample_in = 4'b0001; end
      total++;
      if (valid_out !== 1'b1 || sample_out !== exp[i])
        begin bad++; $display("FAIL six_sample[%0d]: got valid=%b sample=%h, want valid=1 sample=%h",
                              i, valid_out, sample_out, exp[i]); end
      total++;
      if (busy_out !== 1'b1) begin bad++; $display("FAIL six_busy[%0d]: got %b want 1", i, busy_out); end
      #1;
      want_h = (i < 5);
      total++;
      if (halt_us_out !== want_h)
        begin bad++; $display("FAIL six_halt_us[%0d]: got %b want %b", i, halt_us_out, want_h); end
    end
    total++;
    if (tri_out !== {9{24'hA1B2C3}} || color_out !== {3{24'h5E4D3C}})
      begin bad++; $display("FAIL six_payload: got tri=%h color=%h", tri_out, color_out); end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0 || busy_out !== 1'b0)
      begin bad++; $display("FAIL six_end: got valid=%b busy=%b want 0 0", valid_out, busy_out); end
  endtask

  task automatic test_pitch();
    logic [47:0] want;
    logic        want_h;
    present(mk_box(0, 0, 1024, 1024), 4'b0100, 24'h000111);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 0) valid_in = 1'b0;
      want = mk_pt((i % 3) * 512, (i / 3) * 512);
      total++;
      if (valid_out !== 1'b1 || sample_out !== want)
        begin bad++; $display("FAIL pitch_sample[%0d]: got valid=%b sample=%h, want valid=1 sample=%h",
                              i, valid_out, sample_out, want); end
      #1;
      want_h = (i < 8);
      total++;
      if (halt_us_out !== want_h)
        begin bad++; $display("FAIL pitch_halt_us[%0d]: got %b want %b", i, halt_us_out, want_h); end
    end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL pitch_end: got valid=%b want 0", valid_out); end
    present(mk_box(0, 0, 0, 0), 4'b1000, 24'h000111);
    #1;
    total++;
    if (halt_us_out !== 1'b0) begin bad++; $display("FAIL single_pre_halt: got %b want 0", halt_us_out); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1 || sample_out !== mk_pt(0,0) || busy_out !== 1'b0 || halt_us_out !== 1'b0)
      begin bad++; $display("FAIL single_sample: got valid=%b sample=%h busy=%b halt_us=%b, want 1 0 0 0",
                            valid_out, sample_out, busy_out, halt_us_out); end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0 || halt_us_out !== 1'b0)
      begin bad++; $display("FAIL single_end: got valid=%b halt_us=%b want 0 0", valid_out, halt_us_out); end
  endtask

  task automatic test_bad_code();
    logic [47:0] exp [2];
    exp = '{mk_pt(0,0), mk_pt(1024,0)};
    present(mk_box(0, 0, 1024, 0), 4'b0110, 24'h0000BC);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || sample_out !== exp[i])
        begin bad++; $display("FAIL badcode_sample[%0d]: got valid=%b sample=%h, want valid=1 sample=%h",
                              i, valid_out, sample_out, exp[i]); end
    end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL badcode_end: got valid=%b want 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp [4];
    exp = '{mk_pt(0,0), mk_pt(1024,0), mk_pt(2048,2048), mk_pt(3072,2048)};
    present(mk_box(0, 0, 1024, 0), 4'b1000, 24'h00000A);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) present(mk_box(2048, 2048, 3072, 2048), 4'b1000, 24'h00000B);
      if (i == 2) valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || sample_out !== exp[i])
        begin bad++; $display("FAIL b2b_sample[%0d]: got valid=%b sample=%h, want valid=1 sample=%h",
                              i, valid_out, sample_out, exp[i]); end
    end
    total++;
    if (tri_out !== {9{24'h00000B}}) begin bad++; $display("FAIL b2b_payload: got tri=%h", tri_out); end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0 || busy_out !== 1'b0)
      begin bad++; $display("FAIL b2b_end: got valid=%b busy=%b want 0 0", valid_out, busy_out); end
  endtask

  task automatic test_halt();
    logic [47:0] pts [6];
    int          idx [9];
    int          n_new;
    logic [47:0] prev;
    logic        want_h;
    pts = '{mk_pt(0,0), mk_pt(1024,0), mk_pt(2048,0), mk_pt(0,1024), mk_pt(1024,1024), mk_pt(2048,1024)};
    idx = '{0, 1, 1, 1, 1, 2, 3, 4, 5};
    n_new = 0;
    prev  = '1;
    present(mk_box(0, 0, 2048, 1024), 4'b1000, 24'h00C0DE);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || sample_out !== pts[idx[c]])
        begin bad++; $display("FAIL halt_sample[%0d]: got valid=%b sample=%h, want valid=1 sample=%h",
                              c, valid_out, sample_out, pts[idx[c]]); end
      if (valid_out === 1'b1 && sample_out !== prev) n_new++;
      prev = sample_out;
      halt_ds_in = (c >= 1 && c <= 3);
      #1;
      want_h = halt_ds_in || (c < 8);
      total++;
      if (halt_us_out !== want_h)
        begin bad++; $display("FAIL halt_us[%0d]: got %b want %b", c, halt_us_out, want_h); end
    end
    total++;
    if (n_new != 6) begin bad++; $display("FAIL halt_count: got %0d distinct samples want 6", n_new); end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL halt_end: got valid=%b want 0", valid_out); end
  endtask

  task automatic test_async_reset();
    present(mk_box(0, 0, 2048, 1024), 4'b1000, 24'h00BEEF);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    total++;
    if (sample_out !== mk_pt(1024,0) || busy_out !== 1'b1)
      begin bad++; $display("FAIL areset_pre: got sample=%h busy=%b, want %h 1", sample_out, busy_out, mk_pt(1024,0)); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (valid_out !== 1'b0 || sample_out !== 48'h0 || busy_out !== 1'b0 || halt_us_out !== 1'b0 || tri_out !== 216'h0)
      begin bad++; $display("FAIL areset_now: got valid=%b sample=%h busy=%b halt_us=%b, want all 0",
                            valid_out, sample_out, busy_out, halt_us_out); end
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (valid_out !== 1'b0 || busy_out !== 1'b0)
        begin bad++; $display("FAIL areset_after[%0d]: got valid=%b busy=%b want 0 0", i, valid_out, busy_out); end
    end
  endtask

  task automatic test_degenerate();
    present(mk_box(1024, 0, 0, 0), 4'b1000, 24'h0000DD);
    @(posedge clk); #1;
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1 || sample_out !== mk_pt(1024,0) || busy_out !== 1'b0 || halt_us_out !== 1'b0)
      begin bad++; $display("FAIL degen_sample: got valid=%b sample=%h busy=%b halt_us=%b, want 1 %h 0 0",
                            valid_out, sample_out, busy_out, halt_us_out, mk_pt(1024,0)); end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0 || busy_out !== 1'b0)
      begin bad++; $display("FAIL degen_end: got valid=%b busy=%b want 0 0", valid_out, busy_out); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_six_sample();
    test_pitch();
    test_bad_code();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
